// File: rtl/multi_chan_capture_if.sv
// Port bundle for multi_chan_capture: channel samples, session control and the
// capture FIFO read side. master = producer/consumer side, slave = capture block.
interface multi_chan_capture_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_DLY  = 7
);
    localparam int unsigned DW = $clog2(MAX_DLY + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = CHANNELS * WIDTH;

    logic [BW-1:0] din;
    logic          arm;
    logic          mode;
    logic [DW-1:0] dly;
    logic          trig;
    logic          stop;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    modport master (
        output din, arm, mode, dly, trig, stop, out_ready,
        input  out_data, out_valid, count, overflow, busy
    );

    modport slave (
        input  din, arm, mode, dly, trig, stop, out_ready,
        output out_data, out_valid, count, overflow, busy
    );
endinterface

// File: rtl/multi_chan_capture.sv
// Triggered multi-channel sampler: each accepted trigger captures all channels
// a programmable number of cycles later into a small FIFO.
module multi_chan_capture #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_DLY  = 7
) (
    input logic               clk,
    input logic               rst_,
    multi_chan_capture_if.slave bus
);
    localparam int unsigned DW = $clog2(MAX_DLY + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = CHANNELS * WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PL = MAX_DLY + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic          mode_q;
    logic [DW-1:0] dly_q;
    logic          shot_done;
    logic [PL-1:0] pend;
    logic          busy_q;

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic          overflow_q;

    logic          arm_c;
    logic          trig_acc_c;
    logic          push_c;
    logic          pop_c;
    logic          full_c;
    logic          wr_en_c;
    logic [DW:0]   dly_ext_c;
    logic [DW-1:0] dly_clamp_c;
    logic [PL-1:0] pend_next_c;
    logic [CW-1:0] count_next_c;

    // Session control decode and delay clamp
    always_comb begin
        arm_c       = (state == IDLE) && bus.arm;
        trig_acc_c  = (state == ARMED) && bus.trig && !bus.stop && !shot_done;
        dly_ext_c   = {1'b0, bus.dly};
        dly_clamp_c = bus.dly;
        if (dly_ext_c > (DW + 1)'(MAX_DLY)) begin
            dly_clamp_c = DW'(MAX_DLY);
        end
    end

    // Pending line: bit j set means a trigger accepted j+1 edges ago still awaits capture.
    // A bit stops propagating once it has fired, so an all-zero line means nothing pending.
    always_comb begin
        push_c         = (dly_q == '0) && trig_acc_c;
        for (int j = 0; j < int'(MAX_DLY); j++) begin
            if ((dly_q == DW'(j + 1)) && pend[j]) begin
                push_c = 1'b1;
            end
        end
        pend_next_c    = '0;
        pend_next_c[0] = trig_acc_c && (dly_q != '0);
        for (int j = 1; j < int'(PL); j++) begin
            pend_next_c[j] = pend[j-1] && (dly_q != DW'(j));
        end
    end

    // FIFO handshake; a push on a full FIFO only lands when the head leaves on the same edge
    always_comb begin
        pop_c   = valid_q && bus.out_ready;
        full_c  = (count_q == CW'(DEPTH));
        wr_en_c = push_c && (!full_c || pop_c);
        case ({wr_en_c, pop_c})
            2'b10:   count_next_c = count_q + CW'(1);
            2'b01:   count_next_c = count_q - CW'(1);
            default: count_next_c = count_q;
        endcase
    end

    // Session FSM with registered busy
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            dly_q     <= '0;
            shot_done <= 1'b0;
            pend      <= '0;
            busy_q    <= 1'b0;
        end else begin
            pend <= pend_next_c;
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state     <= ARMED;
                        busy_q    <= 1'b1;
                        mode_q    <= bus.mode;
                        dly_q     <= dly_clamp_c;
                        shot_done <= 1'b0;
                    end
                end
                ARMED: begin
                    if (bus.stop || shot_done) begin
                        state <= DRAIN;
                    end
                    if (trig_acc_c && !mode_q) begin
                        shot_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (pend == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture FIFO storage, pointers and status
    always_ff @(posedge clk) begin
        if (!rst_) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= bus.din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_next_c;
            valid_q <= (count_next_c != '0);
            if (arm_c) begin
                overflow_q <= 1'b0;
            end else if (push_c && !wr_en_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_valid = valid_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/multi_chan_capture.md
MULTI_CHAN_CAPTURE -- requirements
Module: multi_chan_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 2: number of sampled channels.
REQ-003 SHALL have parameter DEPTH, default 4: capture FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_DLY, default 7: largest trigger-to-capture delay in cycles; DW = $clog2(MAX_DLY+1).
REQ-005 SHALL have port clk  input  1: the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst_  input  1: reset, synchronous and active-low.
REQ-007 SHALL have port din  input  CHANNELS*WIDTH: channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port arm  input  1: start a capture session; accepted only in IDLE.
REQ-009 SHALL have port mode  input  1: 0 single-shot, 1 continuous; latched with arm.
REQ-010 SHALL have port dly  input  DW: capture delay in cycles; latched with arm; values >MAX_DLY clamp to MAX_DLY.
REQ-011 SHALL have port trig  input  1: capture request, one per high cycle.
REQ-012 SHALL have port stop  input  1: end a continuous session.
REQ-013 SHALL have port out_data  output  CHANNELS*WIDTH: FIFO head word.
REQ-014 SHALL have port out_valid  output  1: FIFO non-empty.
REQ-015 SHALL have port out_ready  input  1: consumer accepts head word.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1): FIFO occupancy.
REQ-017 SHALL have port overflow  output  1: sticky, a capture was dropped.
REQ-018 SHALL have port busy  output  1: state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, ARMED, DRAIN; IDLE->ARMED on arm; arm in ARMED/DRAIN ignored.
REQ-020 SHALL, on arm in IDLE, latch mode and clamped dly and clear overflow.
REQ-021 SHALL ignore trig in IDLE and DRAIN; in ARMED each high trig at edge k enters a MAX_DLY+1-stage pending line.
REQ-022 SHALL push, at edge k+dly, the din value present at edge k+dly into the FIFO (dly=0: same-edge capture); out_valid rises in the cycle after the push edge.
REQ-023 SHALL support overlapping pending triggers; trig on consecutive edges yields pushes on consecutive edges.
REQ-024 SHALL, in single-shot mode, accept only the first trig, then go ARMED->DRAIN on the following edge.
REQ-025 SHALL, in continuous mode, go ARMED->DRAIN on stop; trig coincident with stop is ignored.
REQ-026 SHALL complete all pending captures in DRAIN and go DRAIN->IDLE on the edge after the pending line is empty.
REQ-027 SHALL pop the head word on an edge where out_valid and out_ready are both high; out_data stable while out_valid high and out_ready low.
REQ-028 SHALL, on push with FIFO full and no pop, drop the word, keep contents, set overflow.
REQ-029 SHALL, on push and pop on the same edge with FIFO full, perform both; count unchanged, no overflow.
REQ-030 SHALL keep FIFO order; pointers wrap modulo DEPTH; count exactly 0..DEPTH.

Reset
REQ-031 SHALL, on any edge with rst_ low, set state IDLE, clear pending line, empty FIFO; out_valid=0, count=0, overflow=0, busy=0, out_data=0.
REQ-032 SHALL discard pending captures on reset mid-session; no capture occurs after rst_ returns high without a new arm.

Verification
REQ-033 rst_ low 2 cycles, din toggling, trig high -> out_valid=0, count=0, overflow=0, busy=0 throughout.
REQ-034 ch0 counts +1/cycle from 0x00, ch1 from 0x0A; arm mode=0 dly=2; trig at ch0=0x10 -> one word ch0=0x12, ch1=0x1C; second trig ignored; busy low after push.
REQ-035 mode=1 dly=0, out_ready=0, 5 trigs -> count=4, first 4 words kept in order, overflow=1 after 5th; then out_ready=1 with 6th trig on full FIFO -> push+pop, overflow unchanged.
REQ-036 mode=1 dly=3, trig on 2 consecutive edges -> pushes on 2 consecutive edges, values 3 cycles after each trig.
REQ-037 mode=1 dly=5, trig then stop 2 cycles later -> capture still at trig+5, trig in DRAIN ignored, busy low one edge later.
REQ-038 count=2 with 1 pending capture, rst_ low 1 cycle -> count=0, out_valid=0, no later push.
